// File: rtl/prefix_add.sv
// Kogge-Stone parallel-prefix adder: S = a + b + cin (mod 2^WIDTH) with carry-out,
// result registered once (single-cycle latency, one operand set per cycle).
module prefix_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    // Node 0 is the carry-in (position -1); node i+1 is operand bit i.
    localparam int unsigned NODES  = WIDTH + 1;
    localparam int unsigned LEVELS = $clog2(NODES);
    localparam int unsigned DIST_L = 2 ** (LEVELS - 1);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [NODES-1:0] carry;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    assign gen  = a & b;
    assign prop = a ^ b;

    genvar k;
    for (k = 0; k < LEVELS; k++) begin : g_lvl
        logic [NODES-1:0] g;
        logic [NODES-1:0] p;

        if (k == 0) begin : g_init
            assign g = {gen, cin};
            assign p = {prop, 1'b0};
        end else begin : g_step
            localparam int unsigned DIST = 2 ** (k - 1);

            // Nodes below DIST have no partner and pass through.
            always_comb begin
                g = g_lvl[k-1].g;
                p = g_lvl[k-1].p;
                for (int unsigned j = DIST; j < NODES; j++) begin
                    g[j] = g_lvl[k-1].g[j] | (g_lvl[k-1].p[j] & g_lvl[k-1].g[j-DIST]);
                    p[j] = g_lvl[k-1].p[j] & g_lvl[k-1].p[j-DIST];
                end
            end
        end
    end

    // Final prefix level only needs group generate: node i then spans i-1 down to -1.
    always_comb begin
        carry = g_lvl[LEVELS-1].g;
        for (int unsigned j = DIST_L; j < NODES; j++) begin
            carry[j] = g_lvl[LEVELS-1].g[j]
                     | (g_lvl[LEVELS-1].p[j] & g_lvl[LEVELS-1].g[j-DIST_L]);
        end
    end

    assign sum_c  = prop ^ carry[WIDTH-1:0];
    assign cout_c = carry[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            cout <= 1'b0;
        end else begin
            S    <= sum_c;
            cout <= cout_c;
        end
    end

endmodule

// File: tb/tb_prefix_add.sv
// Scoreboard bench for prefix_add: driver queues expected results, monitor checks
// them one edge later; an 8-bit and a 16-bit instance run side by side.
module tb_prefix_add;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [7:0]  s8;
    logic        c8;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] s16;
    logic        c16;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic        issue = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    prefix_add #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .S    (s8),
        .cout (c8)
    );

    prefix_add #(.WIDTH(16)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .a    (a16),
        .b    (b16),
        .cin  (cin),
        .S    (s16),
        .cout (c16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one vector (called just after a falling edge) and queue its results.
    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [8:0] exp8);
        logic [16:0] e16;
        a     = va;
        b     = vb;
        cin   = vc;
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        e16   = 17'(a16) + 17'(b16) + 17'(cin);
        issue = 1'b1;
        q8.push_back(exp8);
        q16.push_back(e16);
    endtask

    // Monitor: any edge that captured an issued vector must match the queue head.
    initial begin
        logic chk;
        forever begin
            @(posedge clk);
            chk = issue;
            #1;
            if (chk) begin
                if (q8.size() == 0 || q16.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got a result, expected none queued");
                end else begin
                    check("sum8",  32'({c8, s8}),   32'(q8.pop_front()));
                    check("sum16", 32'({c16, s16}), 32'(q16.pop_front()));
                end
            end
        end
    end

    localparam int NDIR = 16;
    logic [7:0] dir_a   [NDIR] = '{8'd0, 8'd100, 8'd20, 8'd33, 8'd100, 8'd177, 8'd90, 8'd24,
                                   8'd0, 8'd200, 8'd255, 8'd255, 8'h0F, 8'h0F, 8'd0, 8'd128};
    logic [7:0] dir_b   [NDIR] = '{8'd65, 8'd24, 8'd178, 8'd63, 8'd40, 8'd54, 8'd60, 8'd76,
                                   8'd1, 8'd100, 8'd0, 8'd255, 8'hF0, 8'hF0, 8'd0, 8'd128};
    logic       dir_c   [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0] dir_exp [NDIR] = '{9'd65, 9'd124, 9'd198, 9'd96, 9'd140, 9'd231, 9'd150, 9'd100,
                                   9'd1, 9'h12C, 9'h100, 9'h1FF, 9'h100, 9'h0FF, 9'h000, 9'h101};

    initial begin
        int waited;
        rst = 1'b1;
        a   = 8'd100;
        b   = 8'd50;
        cin = 1'b0;
        a16 = 16'd1000;
        b16 = 16'd2000;

        // Outputs stay cleared across clock edges while reset is held.
        repeat (3) begin
            @(negedge clk);
            check("reset8",  32'({c8, s8}),   32'd0);
            check("reset16", 32'({c16, s16}), 32'd0);
        end
        rst = 1'b0;
        drive(8'd100, 8'd50, 1'b0, 9'd150);

        for (int i = 0; i < NDIR; i++) begin
            @(negedge clk);
            drive(dir_a[i], dir_b[i], dir_c[i], dir_exp[i]);
        end

        // Outputs hold between edges even when inputs move.
        @(negedge clk);
        drive(8'd200, 8'd100, 1'b0, 9'h12C);
        @(posedge clk);
        #2;
        a = 8'd3;
        b = 8'd4;
        #2;
        check("hold", 32'({c8, s8}), 32'h12C);

        // Mid-stream reset clears outputs without a clock edge.
        @(negedge clk);
        drive(8'd90, 8'd60, 1'b0, 9'd150);
        @(negedge clk);
        issue = 1'b0;
        rst   = 1'b1;
        #1;
        check("midrst8",  32'({c8, s8}),   32'd0);
        check("midrst16", 32'({c16, s16}), 32'd0);
        @(negedge clk);
        check("midrst_hold", 32'({c8, s8}), 32'd0);
        rst = 1'b0;
        drive(8'd33, 8'd63, 1'b0, 9'd96);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        @(negedge clk);
        issue  = 1'b0;
        waited = 0;
        while ((q8.size() != 0 || q16.size() != 0) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, expected 0", q8.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prefix_add.md
Name: prefix_add

Overview:
- Parameterised parallel-prefix (Kogge-Stone) binary adder with a registered sum output.
- Computes S = a + b + cin modulo 2^WIDTH and exposes the carry-out.
- Sits in the datapath as a single-cycle-latency arithmetic stage: operands are presented before a clock edge and the registered result appears after that edge.

Parameters:
- WIDTH, 8, operand and sum width in bits; any integer ≥ 2 is legal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  addend A (unsigned)
- b  input  WIDTH  addend B (unsigned)
- cin  input  1  carry-in
- S  output  WIDTH  registered sum, (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a + b + cin

Behaviour:
- Pre-processing, per bit i:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
- Carry-in handling: cin is injected as an extra generate node at position -1 (G = cin, P = 0).
- Prefix network:
  - Kogge-Stone, ceil(log2(WIDTH+1)) levels.
  - At level k, node i combines with node i - 2^k:
    - G = G_hi | (P_hi & G_lo)
    - P = P_hi & P_lo
  - A node with no partner at distance 2^k passes through unchanged.
  - Build it with generate loops; no behavioural "+" operator anywhere in the adder path.
- Carries and sum:
  - c_0 = cin; c_i = group generate G[i-1 : -1]
  - S_i = p_i ^ c_i
  - cout = G[WIDTH-1 : -1]
- Register stage:
  - S and cout are captured on the rising edge of clk from the combinational result of the a, b, cin values present before that edge.
  - Latency is exactly one clock; a new operand set is accepted every cycle (throughput 1/cycle).
  - Between edges the outputs hold their last captured value, independent of input changes.
- Reset:
  - While rst = 1: S = 0 and cout = 0, applied immediately and without waiting for clk.
  - Asserting rst mid-stream discards the captured result.
  - The first rising edge after rst deasserts captures the current inputs normally.
- Arithmetic: operands are unsigned.
  - Overflow wraps modulo 2^WIDTH and is reported only through cout.
  - No saturation.
  - No signed-overflow flag.
- Boundary conditions:
  - All-ones plus cin = 1 gives S = 0, cout = 1 (the full propagate chain resolves through every prefix level).
  - 0 + 0 + 0 gives S = 0, cout = 0.
  - X/Z on the inputs is not required to be handled.
- Timing: the combinational path from inputs to the register D pins is logarithmic depth.

Test Plan:
- Reset: assert rst with a = 100, b = 50 and toggle clk -> S = 0, cout = 0 throughout; after release, next edge -> S = 150, cout = 0.
- Streaming directed sums, cin = 0, one vector per edge:
  - (0, 65) -> 65
  - (100, 24) -> 124
  - (20, 178) -> 198
  - (33, 63) -> 96
  - (100, 40) -> 140
  - (177, 54) -> 231
  - (90, 60) -> 150
  - (24, 76) -> 100
  - (0, 1) -> 1
  - Each result appears one edge after its operands; cout = 0 for all.
- Carry-out and wrap:
  - a = 200, b = 100, cin = 0 -> S = 44, cout = 1
  - a = 255, b = 0, cin = 1 -> S = 0, cout = 1
  - a = 255, b = 255, cin = 1 -> S = 255, cout = 1
- Carry-in propagation: a = 0x0F, b = 0xF0, cin = 1 -> S = 0x00, cout = 1; same operands with cin = 0 -> S = 0xFF, cout = 0.
- Mid-stream reset: stream vectors, pulse rst between clk edges -> outputs drop to 0 immediately; the following edge after release yields the sum of the then-current inputs.
- Randomised check: 1000 random (a, b, cin) vectors, plus a WIDTH = 16 instance -> {cout, S} equals a + b + cin delayed by one cycle.
